seq_divider: RTL and testbench

//  Multi-cycle restoring divider feeding the Z register pair of the datapath.

---
 rtl/div_pkg.sv | 15 +
 rtl/div_step.sv | 26 ++
 rtl/seq_divider.sv | 156 +++++++++++++++
 tb/tb_seq_divider.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared constants and FSM state type for the sequential restoring divider.
package div_pkg;

  localparam int DIV_WIDTH   = 32;
  localparam int DIV_CNT_W   = 6;
  localparam int DIV_LATENCY = DIV_WIDTH + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift rem:quo left, trial-subtract,
// restore on borrow and shift the new quotient bit in at the bottom.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] trial;
  logic           borrow;

  // Partial remainder is always < divisor, so the shifted value fits in WIDTH+1 bits
  // and the trial difference lies in [-divisor, divisor-1]; its top bit is the borrow.
  assign rem_sh  = {rem_in, quo_in[WIDTH-1]};
  assign trial   = rem_sh - {1'b0, divisor};
  assign borrow  = trial[WIDTH];

  assign rem_out = borrow ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quo_out = {quo_in[WIDTH-2:0], ~borrow};

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock; result = {remainder, quotient}.
// Define DIV_SIGNED_EN for two's-complement operands (truncating division).
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               busy,
  output logic               done,
  output logic               div_zero,
  output logic [2*WIDTH-1:0] result
);

  state_t               state_reg;
  state_t               state_next;
  logic [CNT_W-1:0]     cnt_reg;
  logic [WIDTH-1:0]     quo_reg;
  logic [WIDTH-1:0]     rem_reg;
  logic [WIDTH-1:0]     dvs_reg;
  logic [2*WIDTH-1:0]   result_reg;
  logic                 div_zero_reg;

  logic                 accept;
  logic                 zero_divisor;
  logic [WIDTH-1:0]     abs_dividend;
  logic [WIDTH-1:0]     abs_divisor;
  logic [WIDTH-1:0]     quo_step;
  logic [WIDTH-1:0]     rem_step;
  logic [WIDTH-1:0]     quo_final;
  logic [WIDTH-1:0]     rem_final;

  assign accept       = (state_reg == IDLE) && start;
  assign zero_divisor = (divisor == '0);

`ifdef DIV_SIGNED_EN
  logic neg_quo_reg;
  logic neg_rem_reg;

  // Work on magnitudes; the most negative value maps onto itself, which is the
  // correct unsigned magnitude 2^(WIDTH-1).
  assign abs_dividend = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
  assign abs_divisor  = divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;
  assign quo_final    = neg_quo_reg ? (~quo_reg + 1'b1) : quo_reg;
  assign rem_final    = neg_rem_reg ? (~rem_reg + 1'b1) : rem_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_quo_reg <= 1'b0;
      neg_rem_reg <= 1'b0;
    end else if (accept) begin
      neg_quo_reg <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      neg_rem_reg <= dividend[WIDTH-1];
    end
  end
`else
  assign abs_dividend = dividend;
  assign abs_divisor  = divisor;
  assign quo_final    = quo_reg;
  assign rem_final    = rem_reg;
`endif

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_in  (rem_reg),
    .quo_in  (quo_reg),
    .divisor (dvs_reg),
    .rem_out (rem_step),
    .quo_out (quo_step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = zero_divisor ? DONE : CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (cnt_reg == '0) begin
          state_next = FIX;
        end
      end
      FIX: begin
        busy       = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The quotient register starts out holding the dividend magnitude; its bits are
  // shifted into the remainder one per CALC cycle while quotient bits fill in below.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg      <= '0;
      quo_reg      <= '0;
      rem_reg      <= '0;
      dvs_reg      <= '0;
      result_reg   <= '0;
      div_zero_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            cnt_reg <= CNT_W'(WIDTH - 1);
            quo_reg <= abs_dividend;
            rem_reg <= '0;
            dvs_reg <= abs_divisor;
            if (zero_divisor) begin
              result_reg   <= {dividend, {WIDTH{1'b1}}};
              div_zero_reg <= 1'b1;
            end
          end
        end
        CALC: begin
          cnt_reg <= cnt_reg - 1'b1;
          quo_reg <= quo_step;
          rem_reg <= rem_step;
        end
        FIX: begin
          result_reg   <= {rem_final, quo_final};
          div_zero_reg <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  assign result   = result_reg;
  assign div_zero = div_zero_reg;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed corner cases plus random operands
// compared against a plain-arithmetic reference model (honours DIV_SIGNED_EN).
module tb_seq_divider;
  import div_pkg::*;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   dividend = '0;
  logic [W-1:0]   divisor = '0;
  logic           busy;
  logic           done;
  logic           div_zero;
  logic [2*W-1:0] result;

  int total = 0;
  int bad = 0;

  seq_divider #(
    .WIDTH (W),
    .CNT_W (6)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .result   (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Returns {div_zero, remainder, quotient}.
  function automatic logic [2*W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] q;
    logic [W-1:0] r;
`ifdef DIV_SIGNED_EN
    longint sa;
    longint sb;
`endif
    if (b == '0) return {1'b1, a, {W{1'b1}}};
`ifdef DIV_SIGNED_EN
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    q  = W'(sa / sb);
    r  = W'(sa % sb);
`else
    q  = a / b;
    r  = a % b;
`endif
    return {1'b0, r, q};
  endfunction

  // Issue one division; optionally pulse start with junk operands mid-CALC.
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input bit pulse_mid);
    logic [2*W:0] exp;
    int           lat;
    int           exp_lat;
    exp     = model(a, b);
    exp_lat = (b == '0) ? 1 : DIV_LATENCY;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    lat = 1;
    if (b != '0) check("busy_first", 64'(busy), 64'd1);
    while (done !== 1'b1 && lat < 100) begin
      start = pulse_mid && (lat == 5);
      @(negedge clk);
      start = 1'b0;
      lat++;
    end
    check("latency", 64'(lat), 64'(exp_lat));
    check("result", result, exp[2*W-1:0]);
    check("div_zero", 64'(div_zero), 64'(exp[2*W]));
    check("busy_at_done", 64'(busy), 64'd0);
    $display("txn a=%h b=%h result=%h div_zero=%0b lat=%0d", a, b, result, div_zero, lat);
    @(negedge clk);
    check("done_pulse", 64'(done), 64'd0);
  endtask

  initial begin
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] held;
    int             done_cnt;

    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_div_zero", 64'(div_zero), 64'd0);
    rst_n = 1'b1;

    run_div(32'd34, 32'd15, 1'b0);
    check("case1_literal", result, 64'h00000004_00000002);
    run_div(32'd12, 32'd15, 1'b0);
    run_div(32'hFFFFFFDE, 32'd15, 1'b0);
    run_div(32'd10, 32'd0, 1'b0);
    check("case4_literal", result, 64'h0000000A_FFFFFFFF);
    run_div(32'h80000000, 32'hFFFFFFFF, 1'b0);
    run_div(32'hFFFFFFFF, 32'd1, 1'b0);
    run_div(32'd0, 32'd5, 1'b0);
    run_div(32'd1000, 32'd7, 1'b1);

    // Result must hold while operands wiggle and start stays low.
    held = result;
    repeat (5) begin
      @(negedge clk);
      dividend = $urandom;
      divisor  = $urandom;
    end
    check("hold_result", result, held);

    // Asynchronous clear in the middle of CALC.
    @(negedge clk);
    dividend = 32'd34;
    divisor  = 32'd15;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("clr_busy", 64'(busy), 64'd0);
    check("clr_done", 64'(done), 64'd0);
    check("clr_result", result, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("clr_no_done", 64'(done_cnt), 64'd0);
    run_div(32'd34, 32'd15, 1'b0);

    for (int i = 0; i < 25; i++) begin
      int sel;
      sel = $urandom_range(0, 9);
      a   = $urandom;
      if (sel == 0) b = '0;
      else if (sel < 4) b = W'($urandom_range(1, 20));
      else b = $urandom;
      run_div(a, b, i[0]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
